// File: rtl/axis_interruption_monitor.sv
// -----------------------------------------------------------------------------
// axis_interruption_monitor
// Passive observer on one AXI-Stream link. Decodes every stall gap that
// occurs inside a packet into an event (beat index, gap length, cause),
// emits a per-packet summary on the tlast handshake, and flags handshake
// protocol violations (valid withdrawn or payload changed while stalled).
//
// Ports
//   aclk, aresetn         clock (rising edge), async active-low reset
//   mon_tvalid/tready     observed handshake signals
//   mon_tdata/tlast       observed payload
//   ev_valid              1-cycle pulse: gap decoded; ev_* held until next pulse
//   ev_beat_index         beats completed in the packet before the gap
//   ev_length             stall cycles in the gap (saturating)
//   ev_cause              bit0: tvalid=0 seen, bit1: tvalid=1 & tready=0 seen
//   pkt_done              1-cycle pulse: packet closed; pkt_* held until next
//   pkt_beats/num_int     beats and interruptions in the closed packet
//   pkt_max_len           longest gap in the closed packet
//   err_pulse/err_sticky  protocol violation pulse / latched flag
// -----------------------------------------------------------------------------
module axis_interruption_monitor #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              mon_tvalid,
  input  logic              mon_tready,
  input  logic [DATA_W-1:0] mon_tdata,
  input  logic              mon_tlast,
  output logic              ev_valid,
  output logic [CNT_W-1:0]  ev_beat_index,
  output logic [LEN_W-1:0]  ev_length,
  output logic [1:0]        ev_cause,
  output logic              pkt_done,
  output logic [CNT_W-1:0]  pkt_beats,
  output logic [CNT_W-1:0]  pkt_num_int,
  output logic [LEN_W-1:0]  pkt_max_len,
  output logic              err_pulse,
  output logic              err_sticky
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  state_t              r_state;
  logic [CNT_W-1:0]    r_beat_cnt;
  logic [CNT_W-1:0]    r_num_int;
  logic [LEN_W-1:0]    r_max_len;
  logic [LEN_W-1:0]    r_gap_len;
  logic [1:0]          r_cause;

  // Previous-cycle sample of the link, used by the protocol checker
  logic                r_prev_vld;
  logic                r_prev_rdy;
  logic                r_prev_last;
  logic [DATA_W-1:0]   r_prev_data;

  logic                w_hs;
  logic [1:0]          w_stall_cause;
  logic [CNT_W-1:0]    w_beat_inc;
  logic [CNT_W-1:0]    w_nint_inc;
  logic [LEN_W-1:0]    w_gap_inc;
  logic [LEN_W-1:0]    w_max_upd;
  logic                w_viol;

  assign w_hs          = mon_tvalid & mon_tready;
  assign w_stall_cause = {mon_tvalid & ~mon_tready, ~mon_tvalid};

  // Saturating increments; counters never wrap
  assign w_beat_inc = (r_beat_cnt == CNT_MAX) ? r_beat_cnt : r_beat_cnt + CNT_W'(1);
  assign w_nint_inc = (r_num_int  == CNT_MAX) ? r_num_int  : r_num_int  + CNT_W'(1);
  assign w_gap_inc  = (r_gap_len  == LEN_MAX) ? r_gap_len  : r_gap_len  + LEN_W'(1);
  assign w_max_upd  = (r_gap_len > r_max_len) ? r_gap_len : r_max_len;

  // A stalled beat (valid & ~ready) must stay valid with a stable payload
  assign w_viol = r_prev_vld & ~r_prev_rdy &
                  (~mon_tvalid | (mon_tdata != r_prev_data) | (mon_tlast != r_prev_last));

  // Protocol checker history
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_prev_vld  <= 1'b0;
      r_prev_rdy  <= 1'b0;
      r_prev_last <= 1'b0;
      r_prev_data <= '0;
      err_pulse   <= 1'b0;
      err_sticky  <= 1'b0;
    end else begin
      r_prev_vld  <= mon_tvalid;
      r_prev_rdy  <= mon_tready;
      r_prev_last <= mon_tlast;
      r_prev_data <= mon_tdata;
      err_pulse   <= w_viol;
      if (w_viol) begin
        err_sticky <= 1'b1;
      end
    end
  end

  // Packet / gap tracking FSM with registered event and summary outputs
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state       <= S_IDLE;
      r_beat_cnt    <= '0;
      r_num_int     <= '0;
      r_max_len     <= '0;
      r_gap_len     <= '0;
      r_cause       <= 2'b00;
      ev_valid      <= 1'b0;
      ev_beat_index <= '0;
      ev_length     <= '0;
      ev_cause      <= 2'b00;
      pkt_done      <= 1'b0;
      pkt_beats     <= '0;
      pkt_num_int   <= '0;
      pkt_max_len   <= '0;
    end else begin
      ev_valid <= 1'b0;
      pkt_done <= 1'b0;

      case (r_state)
        // Stalls between packets are idle time, not interruptions
        S_IDLE: begin
          if (w_hs) begin
            if (mon_tlast) begin
              pkt_done    <= 1'b1;
              pkt_beats   <= CNT_W'(1);
              pkt_num_int <= '0;
              pkt_max_len <= '0;
            end else begin
              r_beat_cnt <= CNT_W'(1);
              r_state    <= S_ACTIVE;
            end
          end
        end

        S_ACTIVE: begin
          if (w_hs) begin
            if (mon_tlast) begin
              pkt_done    <= 1'b1;
              pkt_beats   <= w_beat_inc;
              pkt_num_int <= r_num_int;
              pkt_max_len <= r_max_len;
              r_beat_cnt  <= '0;
              r_num_int   <= '0;
              r_max_len   <= '0;
              r_state     <= S_IDLE;
            end else begin
              r_beat_cnt <= w_beat_inc;
            end
          end else begin
            r_gap_len <= LEN_W'(1);
            r_cause   <= w_stall_cause;
            r_state   <= S_GAP;
          end
        end

        // beat count is frozen during a gap, so it is the gap's start index
        S_GAP: begin
          if (w_hs) begin
            ev_valid      <= 1'b1;
            ev_beat_index <= r_beat_cnt;
            ev_length     <= r_gap_len;
            ev_cause      <= r_cause;
            if (mon_tlast) begin
              pkt_done    <= 1'b1;
              pkt_beats   <= w_beat_inc;
              pkt_num_int <= w_nint_inc;
              pkt_max_len <= w_max_upd;
              r_beat_cnt  <= '0;
              r_num_int   <= '0;
              r_max_len   <= '0;
              r_state     <= S_IDLE;
            end else begin
              r_beat_cnt <= w_beat_inc;
              r_num_int  <= w_nint_inc;
              r_max_len  <= w_max_upd;
              r_state    <= S_ACTIVE;
            end
          end else begin
            r_gap_len <= w_gap_inc;
            r_cause   <= r_cause | w_stall_cause;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
